// File: rtl/mw_mem_ctrl_if.sv
// Data-memory request/response bus between the stage-3 controller and the data memory.
// The controller drives the request side and samples the response side.
interface mw_mem_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8
);
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [XLEN-1:0]   dmem_addr;
    logic [MASK_W-1:0] dmem_w_mask;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_resp_valid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req_valid,
        output dmem_addr,
        output dmem_w_mask,
        output dmem_wdata,
        input  dmem_req_ready,
        input  dmem_resp_valid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_addr,
        input  dmem_w_mask,
        input  dmem_wdata,
        output dmem_req_ready,
        output dmem_resp_valid,
        output dmem_rdata
    );
endinterface

// File: rtl/mw_mem_ctrl.sv
// Memory/writeback stage control: decode, byte-lane store formatting, load formatting, stall tracking.
// Latency: stores complete in the request cycle; loads need at least 2 cycles (request, then response).
// Backpressure: stall is held while a request is not accepted or a load response is outstanding.
module mw_mem_ctrl #(
    parameter int XLEN   = 32,
    parameter int MASK_W = XLEN / 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   pc_plus4,
    mw_mem_ctrl_if.master     dmem,
    output logic              stall,
    output logic              rwe,
    output logic [1:0]        wb_sel,
    output logic [XLEN-1:0]   wb_data,
    output logic              misaligned,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int OFF_W = $clog2(MASK_W);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    typedef enum logic [0:0] {IDLE, WAIT_RESP} state_t;

    state_t state, state_nxt;

    logic             is_load;
    logic             is_store;
    logic             dec_rwe;
    logic [1:0]       dec_sel;
    logic             size_legal;
    logic             mem_acc;
    logic             addr_misal;
    logic [OFF_W-1:0] offset;
    logic [MASK_W-1:0] size_mask;

    logic             req_c;
    logic             stall_c;
    logic             rwe_core;
    logic             mis_c;
    logic [1:0]       sel_c;
    logic             load_accept;

    logic [OFF_W-1:0] ld_off_q;
    logic [1:0]       ld_size_q;
    logic             ld_uns_q;
    logic [XLEN-1:0]  ld_sh;
    logic [XLEN-1:0]  ld_fmt;

    // Dword accesses only exist on a 64-bit datapath; otherwise the encoding is illegal.
    assign size_legal = !((XLEN == 32) && (funct3[1:0] == 2'b11));
    assign offset     = addr[OFF_W-1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        dec_rwe  = 1'b0;
        dec_sel  = SEL_ALU;
        case (opcode)
            OP_LOAD: begin
                is_load = 1'b1;
                dec_rwe = size_legal;
                dec_sel = SEL_MEM;
            end
            OP_STORE:  is_store = 1'b1;
            OP_BRANCH: dec_rwe  = 1'b0;
            OP_JAL, OP_JALR: begin
                dec_rwe = 1'b1;
                dec_sel = SEL_PC4;
            end
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC: dec_rwe = 1'b1;
            OP_32, OP_IMM32: dec_rwe = (XLEN == 64);
            default: dec_rwe = 1'b0;
        endcase
    end

    assign mem_acc = (is_load | is_store) & size_legal;

    always_comb begin
        addr_misal = 1'b0;
        size_mask  = '1;
        case (funct3[1:0])
            2'b00: size_mask = MASK_W'(1);
            2'b01: begin
                size_mask  = MASK_W'(3);
                addr_misal = addr[0];
            end
            2'b10: begin
                size_mask  = MASK_W'(15);
                addr_misal = |addr[1:0];
            end
            default: begin
                size_mask  = '1;
                addr_misal = |addr[2:0];
            end
        endcase
    end

    assign dmem.dmem_addr   = {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign dmem.dmem_w_mask = is_store ? (size_mask << offset) : '0;
    assign dmem.dmem_wdata  = store_data << {offset, 3'b000};

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        rwe_core  = 1'b0;
        mis_c     = 1'b0;
        sel_c     = dec_sel;
        case (state)
            IDLE: begin
                rwe_core = dec_rwe;
                mis_c    = in_valid & mem_acc & addr_misal;
                if (in_valid && mem_acc && !addr_misal) begin
                    req_c = 1'b1;
                    if (is_store) begin
                        stall_c = !dmem.dmem_req_ready;
                    end else begin
                        stall_c = 1'b1;
                        if (dmem.dmem_req_ready) state_nxt = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                sel_c    = SEL_MEM;
                stall_c  = !dmem.dmem_resp_valid;
                rwe_core = dmem.dmem_resp_valid;
                if (dmem.dmem_resp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset overrides the handshake outputs combinationally so nothing leaks out while held.
    assign dmem.dmem_req_valid = reset_n & req_c;
    assign stall               = reset_n & stall_c;
    assign misaligned          = reset_n & mis_c;
    assign rwe                 = reset_n & in_valid & rwe_core & !stall_c & !mis_c;
    assign wb_sel              = sel_c;
    assign load_accept         = (state == IDLE) & req_c & is_load & dmem.dmem_req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ld_off_q  <= '0;
            ld_size_q <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_accept) begin
                ld_off_q  <= offset;
                ld_size_q <= funct3[1:0];
                ld_uns_q  <= funct3[2];
            end
        end
    end

    // Format uses the access attributes captured at request time, not the live inputs.
    assign ld_sh = dmem.dmem_rdata >> {ld_off_q, 3'b000};

    always_comb begin
        ld_fmt = ld_sh;
        case (ld_size_q)
            2'b00: ld_fmt = ld_uns_q ? XLEN'(ld_sh[7:0])  : XLEN'($signed(ld_sh[7:0]));
            2'b01: ld_fmt = ld_uns_q ? XLEN'(ld_sh[15:0]) : XLEN'($signed(ld_sh[15:0]));
            2'b10: ld_fmt = ld_uns_q ? XLEN'(ld_sh[31:0]) : XLEN'($signed(ld_sh[31:0]));
            default: ld_fmt = ld_sh;
        endcase
    end

    always_comb begin
        case (sel_c)
            SEL_MEM: wb_data = ld_fmt;
            SEL_PC4: wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mw_mem_ctrl.sv
module tb_mw_mem_ctrl;

    `define CK(n, a, e) chk(n, 64'(a), 64'(e))

    logic        clk;
    logic        reset_n;
    logic        v32, v64;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] addr, sd, alu, pc4, rd;
    logic        rdy32, resp32, rdy64, resp64;

    logic        s32_stall, s32_rwe, s32_mis;
    logic [1:0]  s32_sel;
    logic [31:0] s32_wb;
    logic [31:0] s32_cnt;
    logic        s64_stall, s64_rwe, s64_mis;
    logic [1:0]  s64_sel;
    logic [63:0] s64_wb;
    logic [3:0]  s64_cnt;

    int total = 0;
    int bad   = 0;

    mw_mem_ctrl_if #(.XLEN(32)) if32 ();
    mw_mem_ctrl_if #(.XLEN(64)) if64 ();

    assign if32.dmem_req_ready  = rdy32;
    assign if32.dmem_resp_valid = resp32;
    assign if32.dmem_rdata      = rd[31:0];
    assign if64.dmem_req_ready  = rdy64;
    assign if64.dmem_resp_valid = resp64;
    assign if64.dmem_rdata      = rd;

    mw_mem_ctrl #(.XLEN(32), .CNT_W(32)) d32 (
        .clk(clk), .reset_n(reset_n), .in_valid(v32), .opcode(op), .funct3(f3),
        .addr(addr[31:0]), .store_data(sd[31:0]), .alu_result(alu[31:0]), .pc_plus4(pc4[31:0]),
        .dmem(if32), .stall(s32_stall), .rwe(s32_rwe), .wb_sel(s32_sel), .wb_data(s32_wb),
        .misaligned(s32_mis), .stall_cnt(s32_cnt)
    );

    mw_mem_ctrl #(.XLEN(64), .CNT_W(4)) d64 (
        .clk(clk), .reset_n(reset_n), .in_valid(v64), .opcode(op), .funct3(f3),
        .addr(addr), .store_data(sd), .alu_result(alu), .pc_plus4(pc4),
        .dmem(if64), .stall(s64_stall), .rwe(s64_rwe), .wb_sel(s64_sel), .wb_data(s64_wb),
        .misaligned(s64_mis), .stall_cnt(s64_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
        end
    endtask

    typedef struct {
        bit          req;
        bit          stall;
        bit          rwe;
        bit          mis;
        logic [1:0]  wb_sel;
        logic [63:0] wb_data;
        logic [63:0] daddr;
        logic [7:0]  mask;
        logic [63:0] wdata;
        bit          go_wait;
    } exp_t;

    // Expected outputs straight from the stage's rules, using the live (held) inputs.
    function automatic exp_t model(input int xl, input bit rst_n, input bit waiting, input bit iv,
                                   input logic [6:0] o, input logic [2:0] fn, input logic [63:0] a,
                                   input logic [63:0] s, input logic [63:0] al, input logic [63:0] p4,
                                   input bit rdy, input bit resp, input logic [63:0] r);
        exp_t e;
        int nb, off;
        bit is_ld, is_st, memop, mis_acc, drwe;
        logic [1:0]  dsel;
        logic [63:0] xmask, fld, v;
        e = '{default: 0};
        if (!rst_n) return e;
        nb    = 1 << fn[1:0];
        off   = (xl == 64) ? int'(a[2:0]) : int'(a[1:0]);
        xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        is_ld = (o == 7'h03);
        is_st = (o == 7'h23);
        memop = (is_ld || is_st) && !(xl == 32 && nb == 8);
        mis_acc = memop && ((int'(a[2:0]) % nb) != 0);
        e.daddr = (a - 64'(off)) & xmask;
        e.mask  = is_st ? 8'(((1 << nb) - 1) << off) : 8'h00;
        e.wdata = (s << (8 * off)) & xmask;
        fld = (64'd1 << (8 * nb)) - 64'd1;
        v   = (r >> (8 * off)) & fld;
        if (!fn[2] && v[8*nb-1]) v = v | ~fld;
        v = v & xmask;
        if (waiting) begin
            e.stall   = !resp;
            e.rwe     = resp && iv;
            e.wb_sel  = 2'b01;
            e.wb_data = v;
            e.go_wait = !resp;
            return e;
        end
        drwe = 1'b0;
        dsel = 2'b00;
        case (o)
            7'h03: begin drwe = memop; dsel = 2'b01; end
            7'h6F, 7'h67: begin drwe = 1'b1; dsel = 2'b10; end
            7'h33, 7'h13, 7'h37, 7'h17: drwe = 1'b1;
            7'h3B, 7'h1B: drwe = (xl == 64);
            default: drwe = 1'b0;
        endcase
        e.mis = iv && mis_acc;
        if (iv && memop && !mis_acc) begin
            e.req     = 1'b1;
            e.stall   = is_st ? !rdy : 1'b1;
            e.go_wait = is_ld && rdy;
        end
        e.rwe     = iv && drwe && !e.stall && !e.mis;
        e.wb_sel  = dsel;
        e.wb_data = (dsel == 2'b10) ? (p4 & xmask) : (dsel == 2'b01) ? v : (al & xmask);
        return e;
    endfunction

    bit     m32_wait = 0, m32_wait_n = 0, m64_wait = 0, m64_wait_n = 0;
    longint m32_cnt = 0, m32_cnt_n = 0, m64_cnt = 0, m64_cnt_n = 0;
    exp_t   e32, e64;

    always @(negedge clk) begin
        e32 = model(32, reset_n, m32_wait, v32, op, f3, {32'b0, addr[31:0]}, sd, alu, pc4,
                    rdy32, resp32, {32'b0, rd[31:0]});
        `CK("m32_req", if32.dmem_req_valid, e32.req);
        `CK("m32_stall", s32_stall, e32.stall);
        `CK("m32_rwe", s32_rwe, e32.rwe);
        `CK("m32_mis", s32_mis, e32.mis);
        `CK("m32_cnt", s32_cnt, m32_cnt);
        total++;
        if (s32_stall !== e32.stall) begin
            bad++;
            $display("FAIL m32_direct_stall: got %b want %b (t=%0t)", s32_stall, e32.stall, $time);
        end
        total++;
        if (s32_rwe !== e32.rwe) begin
            bad++;
            $display("FAIL m32_direct_rwe: got %b want %b (t=%0t)", s32_rwe, e32.rwe, $time);
        end
        total++;
        if (if32.dmem_req_valid !== e32.req) begin
            bad++;
            $display("FAIL m32_direct_req: got %b want %b (t=%0t)", if32.dmem_req_valid, e32.req, $time);
        end
        if (e32.rwe) begin
            `CK("m32_sel", s32_sel, e32.wb_sel);
            `CK("m32_wb", s32_wb, e32.wb_data);
        end
        if (e32.req) begin
            `CK("m32_addr", if32.dmem_addr, e32.daddr);
            `CK("m32_mask", if32.dmem_w_mask, e32.mask);
            `CK("m32_wdata", if32.dmem_wdata, e32.wdata);
        end
        m32_wait_n = e32.go_wait;
        m32_cnt_n  = (e32.stall && m32_cnt < 64'hFFFF_FFFF) ? m32_cnt + 1 : m32_cnt;
    end

    always @(negedge clk) begin
        e64 = model(64, reset_n, m64_wait, v64, op, f3, addr, sd, alu, pc4, rdy64, resp64, rd);
        `CK("m64_req", if64.dmem_req_valid, e64.req);
        `CK("m64_stall", s64_stall, e64.stall);
        `CK("m64_rwe", s64_rwe, e64.rwe);
        `CK("m64_mis", s64_mis, e64.mis);
        `CK("m64_cnt", s64_cnt, m64_cnt);
        total++;
        if (s64_stall !== e64.stall) begin
            bad++;
            $display("FAIL m64_direct_stall: got %b want %b (t=%0t)", s64_stall, e64.stall, $time);
        end
        total++;
        if (s64_rwe !== e64.rwe) begin
            bad++;
            $display("FAIL m64_direct_rwe: got %b want %b (t=%0t)", s64_rwe, e64.rwe, $time);
        end
        total++;
        if (if64.dmem_req_valid !== e64.req) begin
            bad++;
            $display("FAIL m64_direct_req: got %b want %b (t=%0t)", if64.dmem_req_valid, e64.req, $time);
        end
        if (e64.rwe) begin
            `CK("m64_sel", s64_sel, e64.wb_sel);
            `CK("m64_wb", s64_wb, e64.wb_data);
        end
        if (e64.req) begin
            `CK("m64_addr", if64.dmem_addr, e64.daddr);
            `CK("m64_mask", if64.dmem_w_mask, e64.mask);
            `CK("m64_wdata", if64.dmem_wdata, e64.wdata);
        end
        m64_wait_n = e64.go_wait;
        m64_cnt_n  = (e64.stall && m64_cnt < 15) ? m64_cnt + 1 : m64_cnt;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m32_wait <= 1'b0; m32_cnt <= 0;
            m64_wait <= 1'b0; m64_cnt <= 0;
        end else begin
            m32_wait <= m32_wait_n; m32_cnt <= m32_cnt_n;
            m64_wait <= m64_wait_n; m64_cnt <= m64_cnt_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input bit w64, input bit r, input bit s);
        if (w64) begin rdy64 = r; resp64 = s; end
        else     begin rdy32 = r; resp32 = s; end
    endtask

    task automatic do_load(input bit w64, input logic [2:0] fn, input logic [63:0] ad,
                           input logic [63:0] rdat, input int rdy_dly, input int resp_dly,
                           input logic [63:0] exp_wb);
        op = 7'h03; f3 = fn; addr = ad; rd = rdat;
        if (w64) v64 = 1'b1; else v32 = 1'b1;
        mem(w64, 1'b0, 1'b0);
        repeat (rdy_dly) tick();
        mem(w64, 1'b1, 1'b0);
        tick();
        mem(w64, 1'b0, 1'b0);
        repeat (resp_dly - 1) tick();
        mem(w64, 1'b0, 1'b1);
        #1;
        `CK("ld_rwe", w64 ? s64_rwe : s32_rwe, 1'b1);
        `CK("ld_wb", w64 ? s64_wb : {32'b0, s32_wb}, exp_wb);
        tick();
        mem(w64, 1'b0, 1'b0);
        v32 = 1'b0; v64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [6:0] alu_ops [9] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h67, 7'h6F, 7'h00, 7'h3B, 7'h1B};

    initial begin
        reset_n = 1'b0; v32 = 1'b0; v64 = 1'b0; op = 7'h00; f3 = 3'b000;
        addr = '0; sd = '0; alu = '0; pc4 = '0; rd = '0;
        rdy32 = 1'b0; resp32 = 1'b0; rdy64 = 1'b0; resp64 = 1'b0;
        repeat (2) tick();
        `CK("rst_stall", s32_stall, 1'b0);
        `CK("rst_req", if32.dmem_req_valid, 1'b0);
        `CK("rst_cnt", s32_cnt, 32'd0);
        reset_n = 1'b1;
        tick();

        v32 = 1'b1; v64 = 1'b1; alu = 64'h1234; pc4 = 64'h104;
        op = 7'h13; #1;
        `CK("addi_rwe", s32_rwe, 1'b1);
        `CK("addi_sel", s32_sel, 2'b00);
        `CK("addi_wb", s32_wb, 32'h1234);
        `CK("addi_req", if32.dmem_req_valid, 1'b0);
        tick();
        op = 7'h6F; #1;
        `CK("jal_sel", s32_sel, 2'b10);
        `CK("jal_wb", s32_wb, 32'h104);
        tick();
        op = 7'h63; #1;
        `CK("br_rwe", s32_rwe, 1'b0);
        `CK("br_stall", s32_stall, 1'b0);
        tick();
        op = 7'h3B; #1;
        `CK("op32_rwe32", s32_rwe, 1'b0);
        `CK("op32_rwe64", s64_rwe, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            op = alu_ops[i]; alu = 64'hFEDC_BA98_0000_0100 + 64'(i); f3 = 3'(i);
            tick();
        end
        v64 = 1'b0; f3 = 3'b000;

        op = 7'h23; f3 = 3'b000; addr = 64'h1003; sd = 64'hAB; rdy32 = 1'b1; #1;
        `CK("sb_mask", if32.dmem_w_mask, 4'b1000);
        `CK("sb_wdata", if32.dmem_wdata, 32'hAB00_0000);
        `CK("sb_addr", if32.dmem_addr, 32'h1000);
        `CK("sb_stall", s32_stall, 1'b0);
        tick();
        f3 = 3'b001; addr = 64'h1002; sd = 64'hBEEF; #1;
        `CK("sh_mask", if32.dmem_w_mask, 4'b1100);
        tick();
        f3 = 3'b010; addr = 64'h1004; sd = 64'hDEAD_BEEF;
        tick();
        v32 = 1'b0; rdy32 = 1'b0;
        tick();

        do_load(1'b0, 3'b001, 64'h1002, 64'h8001_0000, 2, 3, 64'hFFFF_8001);
        `CK("lh_cnt", s32_cnt, 32'd5);
        do_load(1'b0, 3'b101, 64'h1002, 64'h8001_0000, 2, 3, 64'h0000_8001);
        `CK("lhu_cnt", s32_cnt, 32'd10);

        op = 7'h03; f3 = 3'b010; addr = 64'h2000; rd = 64'h1234_5678;
        v32 = 1'b1; rdy32 = 1'b1; resp32 = 1'b1; #1;
        `CK("minlat_rwe0", s32_rwe, 1'b0);
        `CK("minlat_stall0", s32_stall, 1'b1);
        tick();
        rdy32 = 1'b0; #1;
        `CK("minlat_rwe1", s32_rwe, 1'b1);
        `CK("minlat_wb", s32_wb, 32'h1234_5678);
        tick();
        v32 = 1'b0; resp32 = 1'b0;
        tick();

        do_load(1'b0, 3'b000, 64'h2003, 64'h80AA_BBCC, 0, 1, 64'hFFFF_FF80);
        do_load(1'b0, 3'b100, 64'h2001, 64'h0000_F000, 1, 2, 64'h0000_00F0);

        op = 7'h03; f3 = 3'b010; addr = 64'h1002; v32 = 1'b1; rdy32 = 1'b1; #1;
        `CK("mis_flag", s32_mis, 1'b1);
        `CK("mis_req", if32.dmem_req_valid, 1'b0);
        `CK("mis_stall", s32_stall, 1'b0);
        `CK("mis_rwe", s32_rwe, 1'b0);
        tick();
        op = 7'h23; f3 = 3'b001; addr = 64'h1001;
        tick();
        op = 7'h03; f3 = 3'b011; addr = 64'h1000; #1;
        `CK("ld32_req", if32.dmem_req_valid, 1'b0);
        `CK("ld32_rwe", s32_rwe, 1'b0);
        tick();

        op = 7'h23; f3 = 3'b010; addr = 64'h3000; rdy32 = 1'b0;
        repeat (3) tick();
        rdy32 = 1'b1; #1;
        `CK("st_retry_done", s32_stall, 1'b0);
        tick();
        v32 = 1'b0; rdy32 = 1'b0;

        op = 7'h03; f3 = 3'b010; addr = 64'h3000; rd = 64'h55;
        v32 = 1'b1; rdy32 = 1'b1;
        tick();
        rdy32 = 1'b0;
        tick();
        #1 reset_n = 1'b0;
        #1;
        `CK("rstw_stall", s32_stall, 1'b0);
        `CK("rstw_req", if32.dmem_req_valid, 1'b0);
        `CK("rstw_cnt", s32_cnt, 32'd0);
        tick();
        reset_n = 1'b1; resp32 = 1'b1; #1;
        `CK("rstw_late_rwe", s32_rwe, 1'b0);
        tick();
        v32 = 1'b0; resp32 = 1'b0;
        tick();

        v64 = 1'b1; op = 7'h23; f3 = 3'b011; addr = 64'h08; sd = 64'h1122_3344_5566_7788; rdy64 = 1'b1; #1;
        `CK("sd_mask", if64.dmem_w_mask, 8'hFF);
        `CK("sd_wdata", if64.dmem_wdata, 64'h1122_3344_5566_7788);
        `CK("sd_addr", if64.dmem_addr, 64'h08);
        tick();
        f3 = 3'b000; addr = 64'h0D; sd = 64'h5A; #1;
        `CK("sb64_mask", if64.dmem_w_mask, 8'h20);
        `CK("sb64_wdata", if64.dmem_wdata, 64'h0000_5A00_0000_0000);
        tick();
        v64 = 1'b0; rdy64 = 1'b0;

        do_load(1'b1, 3'b110, 64'h4, 64'hFFFF_FFFF_8000_0000, 0, 1, 64'h0000_0000_FFFF_FFFF);
        do_load(1'b1, 3'b010, 64'h4, 64'hFFFF_FFFF_8000_0000, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        do_load(1'b1, 3'b011, 64'h10, 64'h0123_4567_89AB_CDEF, 0, 2, 64'h0123_4567_89AB_CDEF);

        v64 = 1'b1; op = 7'h23; f3 = 3'b011; addr = 64'h0C; rdy64 = 1'b1; #1;
        `CK("sd_mis", s64_mis, 1'b1);
        tick();
        f3 = 3'b010; addr = 64'h40; rdy64 = 1'b0;
        repeat (20) tick();
        `CK("cnt_sat", s64_cnt, 4'hF);
        rdy64 = 1'b1;
        tick();
        v64 = 1'b0; rdy64 = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
